tdc_hit_event_builder: RTL and testbench

Consumes the single-cycle rise/fall edge pulses produced by the hit edge detector, together with the fine interpolation code, and builds one timestamped event per hit. Each event holds the leading-edge coarse/fine time, the pulse width in coarse cycles, the trailing-edge fine code and status flags. Events are buffered in a small FIFO and drained by the readout stage over a valid/ready handshake. Sits directly downstream of the edge detector and upstream of readout/serialisation.

---
 rtl/tdc_pkg.sv | 30 +++
 rtl/tdc_event_fifo.sv | 66 ++++++
 rtl/tdc_hit_event_builder.sv | 152 +++++++++++++++
 tb/tb_tdc_hit_event_builder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC hit event builder: default field widths,
// status flag bit positions, the builder FSM state type and a flag helper.
// Pure declarations; no logic, no latency, no flow control.
package tdc_pkg;

    localparam int TDC_COARSE_W  = 16;
    localparam int TDC_FINE_W    = 8;
    localparam int TDC_DEPTH     = 8;
    localparam int TDC_MAX_WIDTH = 4096;

    // Bit positions inside the 2-bit event flag field.
    localparam int FLAG_RESTART = 0;
    localparam int FLAG_TIMEOUT = 1;

    typedef logic [1:0] flags_t;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_FALL = 1'b1
    } state_e;

    function automatic flags_t mk_flags(input logic timeout, input logic restart);
        flags_t f;
        f               = '0;
        f[FLAG_TIMEOUT] = timeout;
        f[FLAG_RESTART] = restart;
        return f;
    endfunction

endpackage

// File: rtl/tdc_event_fifo.sv
// Single-clock first-word-fall-through FIFO holding DEPTH entries.
// Latency: a word written at edge N is visible on rd_dat in the cycle after N.
// Backpressure: wr_rdy low only when full and no pop this cycle; rd_dat held while rd_vld & !rd_rdy.
// Ports: clk/rst_n (async active-low), wr_vld/wr_rdy/wr_dat push side, rd_vld/rd_rdy/rd_dat pop side.
module tdc_event_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic empty, full, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_vld  = !empty;
    assign do_pop  = rd_vld && rd_rdy;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
    assign wr_rdy  = !full || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/tdc_hit_event_builder.sv
// Builds one timestamped event per TDC hit from rise/fall edge pulses and queues it for readout.
// Latency: edge in cycle N -> event register at N+1 -> FIFO write at end of N+1 -> oEVT_VALID in N+2.
// Backpressure: valid/ready on the FIFO head; events arriving while the FIFO is full are dropped and counted.
// Ports: iCLK0/iRST_N clock and async active-low reset; iRISEEDGE/iFALLEDGE/iFINE edge input;
//        oEVT_VALID/iEVT_READY/oEVT_DATA event output; oDROP_CNT/oERR_CNT saturating status counters.
module tdc_hit_event_builder
    import tdc_pkg::*;
#(
    parameter int COARSE_W  = TDC_COARSE_W,
    parameter int FINE_W    = TDC_FINE_W,
    parameter int DEPTH     = TDC_DEPTH,
    parameter int MAX_WIDTH = TDC_MAX_WIDTH
) (
    input  logic                             iCLK0,
    input  logic                             iRST_N,
    input  logic                             iRISEEDGE,
    input  logic                             iFALLEDGE,
    input  logic [FINE_W-1:0]                iFINE,
    output logic                             oEVT_VALID,
    input  logic                             iEVT_READY,
    output logic [2*COARSE_W+2*FINE_W+1:0]   oEVT_DATA,
    output logic [7:0]                       oDROP_CNT,
    output logic [7:0]                       oERR_CNT
);

    typedef struct packed {
        flags_t              flags;
        logic [COARSE_W-1:0] start_coarse;
        logic [FINE_W-1:0]   start_fine;
        logic [COARSE_W-1:0] width_coarse;
        logic [FINE_W-1:0]   stop_fine;
    } evt_t;

    localparam logic [COARSE_W-1:0] MAX_W = COARSE_W'(MAX_WIDTH);

    logic [COARSE_W-1:0] coarse_q, coarse_d;
    state_e              state_q, state_d;
    logic [COARSE_W-1:0] start_coarse_q, start_coarse_d;
    logic [FINE_W-1:0]   start_fine_q, start_fine_d;
    logic                evt_vld_q, evt_vld_d;
    evt_t                evt_q, evt_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [COARSE_W-1:0] elapsed;
    logic                aged_out;
    logic                err_inc;
    logic                fifo_wr_rdy;

    // Modular difference handles counter wrap between the two edges.
    assign elapsed  = coarse_q - start_coarse_q;
    assign aged_out = (state_q == ST_WAIT_FALL) && (elapsed == MAX_W);

    always_comb begin
        coarse_d       = coarse_q + COARSE_W'(1);
        state_d        = state_q;
        start_coarse_d = start_coarse_q;
        start_fine_d   = start_fine_q;
        evt_vld_d      = 1'b0;
        evt_d          = evt_q;
        err_inc        = 1'b0;

        if (iRISEEDGE && iFALLEDGE) begin
            // Coincident edges are meaningless and discarded; the age limit
            // is independent of the edge inputs, so it can still expire here.
            err_inc = 1'b1;
            if (aged_out) begin
                evt_vld_d = 1'b1;
                evt_d     = '{flags: mk_flags(1'b1, 1'b0), start_coarse: start_coarse_q,
                              start_fine: start_fine_q, width_coarse: MAX_W, stop_fine: '0};
                state_d   = ST_IDLE;
            end
        end else if (state_q == ST_IDLE) begin
            if (iRISEEDGE) begin
                start_coarse_d = coarse_q;
                start_fine_d   = iFINE;
                state_d        = ST_WAIT_FALL;
            end else if (iFALLEDGE) begin
                err_inc = 1'b1;
            end
        end else begin
            if (iFALLEDGE) begin
                evt_vld_d = 1'b1;
                evt_d     = '{flags: mk_flags(1'b0, 1'b0), start_coarse: start_coarse_q,
                              start_fine: start_fine_q, width_coarse: elapsed, stop_fine: iFINE};
                state_d   = ST_IDLE;
            end else if (iRISEEDGE) begin
                // Missed trailing edge: close the open hit and start a new one.
                evt_vld_d      = 1'b1;
                evt_d          = '{flags: mk_flags(1'b0, 1'b1), start_coarse: start_coarse_q,
                                   start_fine: start_fine_q, width_coarse: elapsed, stop_fine: '0};
                start_coarse_d = coarse_q;
                start_fine_d   = iFINE;
            end else if (aged_out) begin
                evt_vld_d = 1'b1;
                evt_d     = '{flags: mk_flags(1'b1, 1'b0), start_coarse: start_coarse_q,
                              start_fine: start_fine_q, width_coarse: MAX_W, stop_fine: '0};
                state_d   = ST_IDLE;
            end
        end

        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        drop_cnt_d = drop_cnt_q;
        if (evt_vld_q && !fifo_wr_rdy && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge iCLK0 or negedge iRST_N) begin
        if (!iRST_N) begin
            coarse_q       <= '0;
            state_q        <= ST_IDLE;
            start_coarse_q <= '0;
            start_fine_q   <= '0;
            evt_vld_q      <= 1'b0;
            evt_q          <= '0;
            drop_cnt_q     <= '0;
            err_cnt_q      <= '0;
        end else begin
            coarse_q       <= coarse_d;
            state_q        <= state_d;
            start_coarse_q <= start_coarse_d;
            start_fine_q   <= start_fine_d;
            evt_vld_q      <= evt_vld_d;
            evt_q          <= evt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    tdc_event_fifo #(
        .WIDTH (2*COARSE_W+2*FINE_W+2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (iCLK0),
        .rst_n  (iRST_N),
        .wr_vld (evt_vld_q),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (evt_q),
        .rd_vld (oEVT_VALID),
        .rd_rdy (iEVT_READY),
        .rd_dat (oEVT_DATA)
    );

    assign oDROP_CNT = drop_cnt_q;
    assign oERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_tdc_hit_event_builder.sv
// Self-checking bench for tdc_hit_event_builder: directed table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_tdc_hit_event_builder;

    localparam int CW    = 16;
    localparam int FW    = 8;
    localparam int DEPTH = 8;
    localparam int MAXW  = 4096;
    localparam int DW    = 2*CW + 2*FW + 2;

    logic          iCLK0      = 1'b0;
    logic          iRST_N     = 1'b0;
    logic          iRISEEDGE  = 1'b0;
    logic          iFALLEDGE  = 1'b0;
    logic [FW-1:0] iFINE      = '0;
    logic          iEVT_READY = 1'b0;
    logic          oEVT_VALID;
    logic [DW-1:0] oEVT_DATA;
    logic [7:0]    oDROP_CNT;
    logic [7:0]    oERR_CNT;

    always #5 iCLK0 = ~iCLK0;

    tdc_hit_event_builder #(
        .COARSE_W (CW), .FINE_W (FW), .DEPTH (DEPTH), .MAX_WIDTH (MAXW)
    ) dut (
        .iCLK0      (iCLK0),
        .iRST_N     (iRST_N),
        .iRISEEDGE  (iRISEEDGE),
        .iFALLEDGE  (iFALLEDGE),
        .iFINE      (iFINE),
        .oEVT_VALID (oEVT_VALID),
        .iEVT_READY (iEVT_READY),
        .oEVT_DATA  (oEVT_DATA),
        .oDROP_CNT  (oDROP_CNT),
        .oERR_CNT   (oERR_CNT)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: hit tracker plus an ideal bounded queue.
    logic          m_busy;
    logic [CW-1:0] m_sc;
    logic [FW-1:0] m_sf;
    logic [CW-1:0] m_cnt;
    logic [DW-1:0] m_q[$];
    logic          m_pv;
    logic [DW-1:0] m_pd;
    logic [7:0]    m_err;
    logic [7:0]    m_drop;

    function automatic logic [DW-1:0] ev(input logic [1:0] fl, input logic [CW-1:0] sc,
                                         input logic [FW-1:0] sf, input logic [CW-1:0] w,
                                         input logic [FW-1:0] pf);
        return {fl, sc, sf, w, pf};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sc   = '0;
        m_sf   = '0;
        m_cnt  = '0;
        m_q.delete();
        m_pv   = 1'b0;
        m_pd   = '0;
        m_err  = '0;
        m_drop = '0;
    endtask

    task automatic m_emit(input logic [DW-1:0] d);
        m_pv = 1'b1;
        m_pd = d;
    endtask

    task automatic m_bump_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // One clock edge of the reference: queue movement first, then edge rules.
    task automatic model_step(input logic r, input logic f, input logic [FW-1:0] fi, input logic rd);
        logic          pop;
        logic          acc;
        logic [CW-1:0] el;
        pop = (m_q.size() > 0) && rd;
        acc = m_pv && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(m_pd);
        else if (m_pv && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        m_pv = 1'b0;

        el = m_cnt - m_sc;
        if (r && f) begin
            m_bump_err();
            if (m_busy && el == CW'(MAXW)) begin
                m_emit(ev(2'b10, m_sc, m_sf, CW'(MAXW), '0));
                m_busy = 1'b0;
            end
        end else if (!m_busy) begin
            if (r) begin
                m_busy = 1'b1; m_sc = m_cnt; m_sf = fi;
            end else if (f) begin
                m_bump_err();
            end
        end else if (f) begin
            m_emit(ev(2'b00, m_sc, m_sf, el, fi));
            m_busy = 1'b0;
        end else if (r) begin
            m_emit(ev(2'b01, m_sc, m_sf, el, '0));
            m_sc = m_cnt; m_sf = fi;
        end else if (el == CW'(MAXW)) begin
            m_emit(ev(2'b10, m_sc, m_sf, CW'(MAXW), '0));
            m_busy = 1'b0;
        end
        m_cnt = m_cnt + CW'(1);
    endtask

    task automatic check_model();
        chk("model_valid", 64'(oEVT_VALID), 64'(m_q.size() > 0));
        if (m_q.size() > 0) chk("model_data", 64'(oEVT_DATA), 64'(m_q[0]));
        chk("model_err", 64'(oERR_CNT), 64'(m_err));
        chk("model_drop", 64'(oDROP_CNT), 64'(m_drop));
    endtask

    task automatic cyc_begin(input logic r, input logic f, input logic [FW-1:0] fi, input logic rd);
        iRISEEDGE  = r;
        iFALLEDGE  = f;
        iFINE      = fi;
        iEVT_READY = rd;
        @(negedge iCLK0);
        check_model();
    endtask

    task automatic cyc_end();
        @(posedge iCLK0);
        model_step(iRISEEDGE, iFALLEDGE, iFINE, iEVT_READY);
        #1;
    endtask

    task automatic cyc(input logic r, input logic f, input logic [FW-1:0] fi, input logic rd);
        cyc_begin(r, f, fi, rd);
        cyc_end();
    endtask

    // Called 1 ns after a rising edge; the following cycle has coarse time 0.
    task automatic do_reset();
        iRST_N = 1'b0;
        iRISEEDGE = 1'b0; iFALLEDGE = 1'b0; iFINE = '0; iEVT_READY = 1'b0;
        #2;
        model_reset();
        iRST_N = 1'b1;
    endtask

    typedef struct {
        logic          r;
        logic          f;
        logic [FW-1:0] fi;
        logic          rd;
        logic          vld;
        logic [DW-1:0] dat;
        logic [7:0]    err;
    } vec_t;

    vec_t tbl[24];

    initial begin
        // Directed table: index == coarse time after reset release.
        for (int i = 0; i < 24; i++) tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, {DW{1'b0}}, 8'd0};
        tbl[5].r  = 1'b1; tbl[5].fi  = 8'h12;
        tbl[12].f = 1'b1; tbl[12].fi = 8'h34;
        tbl[14].vld = 1'b1;
        tbl[14].dat = ev(2'b00, 16'd5, 8'h12, 16'd7, 8'h34);
        tbl[16].f = 1'b1;                       // orphan trailing edge
        tbl[19].r = 1'b1; tbl[19].f = 1'b1;     // coincident edges
        for (int i = 17; i < 20; i++) tbl[i].err = 8'd1;
        for (int i = 20; i < 24; i++) tbl[i].err = 8'd2;

        @(posedge iCLK0); #1;
        do_reset();

        for (int i = 0; i < 24; i++) begin
            cyc_begin(tbl[i].r, tbl[i].f, tbl[i].fi, tbl[i].rd);
            chk("tbl_valid", 64'(oEVT_VALID), 64'(tbl[i].vld));
            if (tbl[i].vld) chk("tbl_data", 64'(oEVT_DATA), 64'(tbl[i].dat));
            chk("tbl_err", 64'(oERR_CNT), 64'(tbl[i].err));
            chk("tbl_drop", 64'(oDROP_CNT), 64'd0);
            cyc_end();
        end

        // Missed trailing edge: restart event then normal event.
        @(posedge iCLK0); #1; do_reset();
        repeat (3) cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h21, 0);                    // t=3
        repeat (3) cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h22, 0);                    // t=7
        cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h23, 0);                    // t=9
        cyc(0, 0, 8'h00, 0);
        cyc_begin(0, 0, 8'h00, 1);              // t=11
        chk("restart_valid", 64'(oEVT_VALID), 64'd1);
        chk("restart_evt1", 64'(oEVT_DATA), 64'(ev(2'b01, 16'd3, 8'h21, 16'd4, 8'h00)));
        cyc_end();
        cyc_begin(0, 0, 8'h00, 0);
        chk("restart_evt2", 64'(oEVT_DATA), 64'(ev(2'b00, 16'd7, 8'h22, 16'd2, 8'h23)));
        cyc_end();

        // FIFO overflow with readout stalled, then in-order drain.
        @(posedge iCLK0); #1; do_reset();
        for (int k = 0; k < DEPTH + 3; k++) begin
            cyc(1, 0, 8'(k), 0);
            cyc(0, 1, 8'(8'h80 + k), 0);
        end
        repeat (2) cyc(0, 0, 8'h00, 0);
        for (int s = 0; s < 3; s++) begin
            cyc_begin(0, 0, 8'h00, 0);
            chk("full_valid", 64'(oEVT_VALID), 64'd1);
            chk("full_hold", 64'(oEVT_DATA), 64'(ev(2'b00, 16'd0, 8'h00, 16'd1, 8'h80)));
            chk("full_drop", 64'(oDROP_CNT), 64'd3);
            cyc_end();
        end
        for (int j = 0; j < DEPTH; j++) begin
            cyc_begin(0, 0, 8'h00, 1);
            chk("drain_data", 64'(oEVT_DATA),
                64'(ev(2'b00, 16'(2*j), 8'(j), 16'd1, 8'(8'h80 + j))));
            cyc_end();
        end
        cyc_begin(0, 0, 8'h00, 1);
        chk("drain_empty", 64'(oEVT_VALID), 64'd0);
        cyc_end();

        // Timeout after MAX_WIDTH cycles, then a fresh hit is accepted.
        @(posedge iCLK0); #1; do_reset();
        repeat (2) cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h55, 0);                    // t=2
        repeat (MAXW) cyc(0, 0, 8'h00, 0);      // t=3..4098
        cyc_begin(0, 0, 8'h00, 0);              // t=4099
        chk("tmo_not_yet", 64'(oEVT_VALID), 64'd0);
        cyc_end();
        cyc_begin(1, 0, 8'h77, 0);              // t=4100
        chk("tmo_valid", 64'(oEVT_VALID), 64'd1);
        chk("tmo_data", 64'(oEVT_DATA), 64'(ev(2'b10, 16'd2, 8'h55, 16'd4096, 8'h00)));
        cyc_end();
        repeat (2) cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h66, 0);                    // t=4103
        cyc(0, 0, 8'h00, 0);
        cyc_begin(0, 0, 8'h00, 1);              // t=4105
        chk("tmo_head", 64'(oEVT_DATA), 64'(ev(2'b10, 16'd2, 8'h55, 16'd4096, 8'h00)));
        cyc_end();
        cyc_begin(0, 0, 8'h00, 0);
        chk("tmo_next", 64'(oEVT_DATA), 64'(ev(2'b00, 16'd4100, 8'h77, 16'd3, 8'h66)));
        chk("tmo_err", 64'(oERR_CNT), 64'd0);
        cyc_end();

        // Randomized traffic against the reference model.
        @(posedge iCLK0); #1; do_reset();
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 8'($urandom),
                (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with queued events and an open hit.
        @(posedge iCLK0); #1; do_reset();
        cyc(0, 1, 8'h30, 0);                    // orphan, err=1
        cyc(1, 0, 8'h31, 0);
        cyc(0, 1, 8'h32, 0);
        cyc(1, 0, 8'h33, 0);
        cyc(0, 1, 8'h34, 0);
        cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h35, 0);                    // WAIT_FALL, 2 events queued
        iRST_N = 1'b0;
        #1;
        chk("rst_valid", 64'(oEVT_VALID), 64'd0);
        chk("rst_data", 64'(oEVT_DATA), 64'd0);
        chk("rst_err", 64'(oERR_CNT), 64'd0);
        chk("rst_drop", 64'(oDROP_CNT), 64'd0);
        do_reset();
        cyc(0, 1, 8'h36, 1);
        for (int s = 0; s < 3; s++) begin
            cyc_begin(0, 0, 8'h00, 1);
            chk("post_rst_valid", 64'(oEVT_VALID), 64'd0);
            chk("post_rst_err", 64'(oERR_CNT), 64'd1);
            cyc_end();
        end

        // Coarse counter wrap between leading and trailing edge.
        @(posedge iCLK0); #1; do_reset();
        repeat (16'hFFFE) cyc(0, 0, 8'h00, 0);
        cyc(1, 0, 8'h01, 0);                    // t=0xFFFE
        repeat (4) cyc(0, 0, 8'h00, 0);
        cyc(0, 1, 8'h02, 0);                    // t=3
        cyc(0, 0, 8'h00, 0);
        cyc_begin(0, 0, 8'h00, 0);              // t=5
        chk("wrap_valid", 64'(oEVT_VALID), 64'd1);
        chk("wrap_data", 64'(oEVT_DATA), 64'(ev(2'b00, 16'hFFFE, 8'h01, 16'd5, 8'h02)));
        cyc_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
